// File: rtl/usbh_tx_sched.sv
// usbh_tx_sched: transmit-side sequencer between the host TX byte FIFO and the SIE.
// On start it pops exactly len_i bytes from the FIFO, one at a time, and hands each to
// the SIE through a valid/accept handshake. It flags the final byte, declares underrun
// after TO_CYC consecutive empty cycles while waiting for data, and supports abort with
// a FIFO flush.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   start_i, len_i           start command and byte count (sampled in IDLE only)
//   abort_i                  cancel transfer, flush FIFO (highest priority)
//   fifo_empty_i/data_i      FIFO status and head data
//   fifo_pop_o/flush_o       FIFO strobes
//   sie_data_o/valid_o/last_o, sie_accept_i   byte handshake to the SIE
//   busy_o, done_o, underrun_o, remaining_o   status
module usbh_tx_sched #(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned TO_W   = 8,
  parameter int unsigned TO_CYC = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  input  logic             fifo_empty_i,
  input  logic [7:0]       fifo_data_i,
  output logic             fifo_pop_o,
  output logic             fifo_flush_o,
  output logic [7:0]       sie_data_o,
  output logic             sie_valid_o,
  output logic             sie_last_o,
  input  logic             sie_accept_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  output logic [LEN_W-1:0] remaining_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StFetch   = 2'd1;
  localparam logic [1:0] StPresent = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [TO_W-1:0]  stall_q, stall_d;
  logic [TO_W-1:0]  stall_inc;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;

  assign stall_inc = stall_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    stall_d    = stall_q;
    data_d     = data_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    if (abort_i) begin
      // Abort overrides any coincident start, accept or pop.
      state_d = StIdle;
      rem_d   = '0;
      stall_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (len_i != '0) begin
              rem_d   = len_i;
              stall_d = '0;
              state_d = StFetch;
            end else begin
              done_d = 1'b1;  // zero-length packet completes immediately
            end
          end
        end
        StFetch: begin
          if (!fifo_empty_i) begin
            data_d  = fifo_data_i;
            stall_d = '0;
            state_d = StPresent;
          end else if (stall_inc == TO_W'(TO_CYC)) begin
            underrun_d = 1'b1;
            stall_d    = '0;
            rem_d      = '0;
            state_d    = StIdle;
          end else begin
            stall_d = stall_inc;
          end
        end
        StPresent: begin
          if (sie_accept_i) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StFetch;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      stall_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      stall_q    <= stall_d;
      data_q     <= data_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign fifo_pop_o   = (state_q == StFetch) & ~fifo_empty_i & ~abort_i;
  // Gated by reset so an abort held during reset cannot flush the FIFO.
  assign fifo_flush_o = (abort_i & ~rst_i) | underrun_q;
  assign sie_data_o   = data_q;
  assign sie_valid_o  = (state_q == StPresent);
  assign sie_last_o   = (state_q == StPresent) & (rem_q == LEN_W'(1));
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign underrun_o   = underrun_q;
  assign remaining_o  = rem_q;

endmodule
